// File: rtl/ddram_responder.sv
// ddram_responder: Avalon-style burst memory model with a 64-bit data path.
// It has a byte-enabled backing store and a configurable read latency.
// Bursts are 1..128 beats. The word index wraps modulo the store depth.
// Any protocol violation produces a single-cycle proto_err pulse.
module ddram_responder #(
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        ddram_busy,
    input  logic [7:0]  ddram_burstcnt,
    input  logic [28:0] ddram_addr,
    input  logic        ddram_rd,
    input  logic        ddram_we,
    input  logic [63:0] ddram_din,
    input  logic [7:0]  ddram_be,
    output logic [63:0] ddram_dout,
    output logic        ddram_dout_ready,
    input  logic        stall_in,
    output logic        proto_err
);

    localparam int DEPTH = 1 << ADDR_W;
    // The latency countdown starts at RD_LATENCY-2.
    // This places the first beat in the register that updates at edge T+RD_LATENCY-1.
    localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 2);
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_LAT   = 2'd1,
        RD_BURST = 2'd2,
        WR_BURST = 2'd3
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   idx_reg;        // next word to read or write
    logic [7:0]          left_reg;       // beats still to issue
    logic [3:0]          lat_reg;        // read latency countdown
    logic                ready_reg;      // low for the first edge after reset
    logic                dout_ready_reg;
    logic                proto_err_reg;
    logic                have_data_reg;  // dout shows zero until the first read after reset
    logic [63:0]         rd_q;           // registered RAM read port

    logic [63:0]         mem [0:DEPTH-1];

    logic                burst_legal;
    logic                idle_open;
    logic                acc_rd;
    logic                acc_we0;
    logic                wr_beat;
    logic                err_now;
    logic                rd_en;
    logic                wr_en;
    logic [ADDR_W-1:0]   addr_idx;
    logic [ADDR_W-1:0]   wr_idx;

    generate
        if (ADDR_W < 29) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^ddram_addr[28:ADDR_W];
        end
    endgenerate

    // Busy is held high while a read is in flight and on the first edge after reset.
    // Otherwise the stall hook drives it.
    assign ddram_busy = !ready_reg || (state_reg == RD_LAT) ||
                        (state_reg == RD_BURST) || stall_in;

    assign addr_idx    = ddram_addr[ADDR_W-1:0];
    assign burst_legal = (ddram_burstcnt != 8'd0) && (ddram_burstcnt <= 8'd128);
    assign idle_open   = (state_reg == IDLE) && !ddram_busy;

    // In IDLE, a read takes priority over a simultaneous write.
    assign acc_rd  = idle_open && ddram_rd && burst_legal;
    assign acc_we0 = idle_open && ddram_we && !ddram_rd && burst_legal;
    assign wr_beat = (state_reg == WR_BURST) && ddram_we && !ddram_busy;

    // A violation is any of the following:
    // - an illegal length on any request,
    // - a read and a write presented together,
    // - a read presented during a write burst.
    assign err_now = (idle_open && (ddram_rd || ddram_we) &&
                      (!burst_legal || (ddram_rd && ddram_we))) ||
                     ((state_reg == WR_BURST) && !ddram_busy && ddram_rd);

    assign rd_en  = ((state_reg == RD_LAT) && (lat_reg == 4'd0)) ||
                    ((state_reg == RD_BURST) && (left_reg != 8'd0));
    assign wr_en  = acc_we0 || wr_beat;
    assign wr_idx = (state_reg == IDLE) ? addr_idx : idx_reg;

    // Backing store: a byte-enabled write port and a registered read port.
    // Reset does not touch the stored contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (ddram_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= ddram_din[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_q <= mem[idx_reg];
        end
    end

    assign ddram_dout       = have_data_reg ? rd_q : 64'd0;
    assign ddram_dout_ready = dout_ready_reg;
    assign proto_err        = proto_err_reg;

    // Burst sequencing FSM with registered beat-valid and error outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            left_reg       <= 8'd0;
            lat_reg        <= 4'd0;
            ready_reg      <= 1'b0;
            dout_ready_reg <= 1'b0;
            proto_err_reg  <= 1'b0;
            have_data_reg  <= 1'b0;
        end else begin
            ready_reg      <= 1'b1;
            dout_ready_reg <= rd_en;
            proto_err_reg  <= err_now;
            if (rd_en) begin
                have_data_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (acc_rd) begin
                        idx_reg   <= addr_idx;
                        left_reg  <= ddram_burstcnt;
                        lat_reg   <= LAT_INIT;
                        state_reg <= RD_LAT;
                    end else if (acc_we0 && (ddram_burstcnt != 8'd1)) begin
                        idx_reg   <= addr_idx + IDX_ONE;
                        left_reg  <= ddram_burstcnt - 8'd1;
                        state_reg <= WR_BURST;
                    end
                end
                RD_LAT: begin
                    if (lat_reg == 4'd0) begin
                        idx_reg   <= idx_reg + IDX_ONE;
                        left_reg  <= left_reg - 8'd1;
                        state_reg <= RD_BURST;
                    end else begin
                        lat_reg <= lat_reg - 4'd1;
                    end
                end
                RD_BURST: begin
                    if (left_reg != 8'd0) begin
                        idx_reg  <= idx_reg + IDX_ONE;
                        left_reg <= left_reg - 8'd1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                WR_BURST: begin
                    if (wr_beat) begin
                        idx_reg  <= idx_reg + IDX_ONE;
                        left_reg <= left_reg - 8'd1;
                        if (left_reg == 8'd1) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddram_responder.sv
// Testbench for ddram_responder.
// Read beats are checked against a scoreboard of expected data and sample cycle.
// The expected data comes from a reference memory updated by the bench's own writes.
module tb_ddram_responder;

    localparam int ADDR_W = 10;
    localparam int L      = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk;
    logic        reset_n;
    logic        ddram_busy;
    logic [7:0]  ddram_burstcnt;
    logic [28:0] ddram_addr;
    logic        ddram_rd;
    logic        ddram_we;
    logic [63:0] ddram_din;
    logic [7:0]  ddram_be;
    logic [63:0] ddram_dout;
    logic        ddram_dout_ready;
    logic        stall_in;
    logic        proto_err;

    ddram_responder #(.ADDR_W(ADDR_W), .RD_LATENCY(L)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ddram_busy       (ddram_busy),
        .ddram_burstcnt   (ddram_burstcnt),
        .ddram_addr       (ddram_addr),
        .ddram_rd         (ddram_rd),
        .ddram_we         (ddram_we),
        .ddram_din        (ddram_din),
        .ddram_be         (ddram_be),
        .ddram_dout       (ddram_dout),
        .ddram_dout_ready (ddram_dout_ready),
        .stall_in         (stall_in),
        .proto_err        (proto_err)
    );

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [63:0] model [0:DEPTH-1];
    logic [63:0] wdata [0:7];
    logic [7:0]  wbe   [0:7];
    int          checks = 0;
    int          passes = 0;
    int          cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every read beat must match the next scoreboard entry in both data and cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset_n === 1'b1 && ddram_dout_ready === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_beat: dout_ready=1 dout=%h at cyc %0d, required no beat", ddram_dout, cyc);
            end else begin
                e = q.pop_front();
                if (ddram_dout !== e.data || cyc != e.cyc) begin
                    $display("FAIL read_beat: dout=%h cyc=%0d, required dout=%h cyc=%0d",
                             ddram_dout, cyc, e.data, e.cyc);
                end else begin
                    passes++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input string what);
        int n = 0;
        while (ddram_busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ddram_busy !== 1'b0)
            $display("FAIL %s: busy=%b after 20 cycles, required 0", what, ddram_busy);
        else
            passes++;
    endtask

    // Called and returning just after a negedge; the request is accepted on the following edge.
    task automatic do_read(input logic [28:0] a, input int n, input bit with_we);
        int t;
        int bad = 0;
        int last;
        ddram_addr     = a;
        ddram_burstcnt = 8'(n);
        ddram_rd       = 1'b1;
        ddram_we       = with_we;
        ddram_din      = 64'hDEAD_BEEF_0BAD_F00D;
        ddram_be       = 8'hFF;
        wait_ready("rd_accept");
        t = cyc + 1;
        for (int k = 0; k < n; k++)
            q.push_back('{data: model[(int'(a[ADDR_W-1:0]) + k) % DEPTH], cyc: t + L - 1 + k});
        @(negedge clk);
        ddram_rd = 1'b0;
        ddram_we = 1'b0;
        checks++;
        if (proto_err !== with_we)
            $display("FAIL rd_proto_err: proto_err=%b, required %b", proto_err, with_we);
        else
            passes++;
        while (cyc < t + L + n - 1) begin
            if (ddram_busy !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) $display("FAIL busy_in_read: %0d cycles busy=0, required 0 cycles", bad);
        else passes++;
        checks++;
        if (ddram_busy !== 1'b0 || ddram_dout_ready !== 1'b0)
            $display("FAIL busy_after_read: busy=%b dout_ready=%b, required 0 0", ddram_busy, ddram_dout_ready);
        else
            passes++;
        last = (int'(a[ADDR_W-1:0]) + n - 1) % DEPTH;
        checks++;
        if (ddram_dout !== model[last])
            $display("FAIL dout_hold: dout=%h, required %h", ddram_dout, model[last]);
        else
            passes++;
        checks++;
        if (q.size() != 0) $display("FAIL beats_missing: %0d beats outstanding, required 0", q.size());
        else passes++;
        q.delete();
    endtask

    // Writes n beats from wdata/wbe.
    // stall_at: beat index preceded by a two-cycle stall carrying garbage data, then a we=0 gap.
    // rd_at: beat index where rd is also asserted.
    task automatic do_write(input logic [28:0] a, input int n, input int stall_at, input int rd_at);
        int i;
        ddram_addr     = a;
        ddram_burstcnt = 8'(n);
        for (int k = 0; k < n; k++) begin
            if (k == stall_at) begin
                stall_in  = 1'b1;
                ddram_we  = 1'b1;
                ddram_din = 64'h0BAD_0BAD_0BAD_0BAD;
                ddram_be  = 8'hFF;
                repeat (2) @(negedge clk);
                checks++;
                if (ddram_busy !== 1'b1) $display("FAIL stall_busy: busy=%b, required 1", ddram_busy);
                else passes++;
                stall_in = 1'b0;
                ddram_we = 1'b0;
                @(negedge clk);
            end
            ddram_we  = 1'b1;
            ddram_din = wdata[k];
            ddram_be  = wbe[k];
            ddram_rd  = (k == rd_at);
            wait_ready("wr_accept");
            @(negedge clk);
            i = (int'(a[ADDR_W-1:0]) + k) % DEPTH;
            for (int b = 0; b < 8; b++)
                if (wbe[k][b]) model[i][8*b +: 8] = wdata[k][8*b +: 8];
            if (k == rd_at) begin
                checks++;
                if (proto_err !== 1'b1) $display("FAIL rd_in_wr_err: proto_err=%b, required 1", proto_err);
                else passes++;
                ddram_rd = 1'b0;
            end
        end
        ddram_we = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; stall_in = 1'b0; ddram_rd = 1'b0; ddram_we = 1'b0;
        ddram_addr = '0; ddram_burstcnt = 8'd0; ddram_din = '0; ddram_be = '0;
        #2;
        checks += 4;
        if (ddram_busy !== 1'b1) $display("FAIL rst_busy: busy=%b, required 1", ddram_busy); else passes++;
        if (ddram_dout_ready !== 1'b0) $display("FAIL rst_ready: dout_ready=%b, required 0", ddram_dout_ready); else passes++;
        if (ddram_dout !== 64'd0) $display("FAIL rst_dout: dout=%h, required 0", ddram_dout); else passes++;
        if (proto_err !== 1'b0) $display("FAIL rst_err: proto_err=%b, required 0", proto_err); else passes++;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (ddram_busy !== 1'b1) $display("FAIL rel_busy_first: busy=%b, required 1", ddram_busy); else passes++;
        @(negedge clk);
        checks++;
        if (ddram_busy !== 1'b0) $display("FAIL rel_busy_second: busy=%b, required 0", ddram_busy); else passes++;
    endtask

    task automatic test_single;
        wdata[0] = 64'h1122_3344_5566_7788; wbe[0] = 8'hFF;
        do_write(29'd5, 1, -1, -1);
        do_read(29'd5, 1, 1'b0);
    endtask

    task automatic test_stall_be;
        for (int k = 0; k < 4; k++) begin wdata[k] = '1; wbe[k] = 8'hFF; end
        do_write(29'h10, 4, -1, -1);
        for (int k = 0; k < 4; k++) begin wdata[k] = 64'hA0 + 64'(k); wbe[k] = 8'hFF; end
        wbe[2] = 8'h01;
        do_write(29'h10, 4, 2, -1);
        do_read(29'h10, 4, 1'b0);
    endtask

    task automatic test_wrap;
        for (int k = 0; k < 8; k++) begin wdata[k] = 64'hC0DE_0000_0000_0000 | 64'(k); wbe[k] = 8'hFF; end
        do_write(29'd1020, 8, -1, -1);
        do_read(29'd1020, 8, 1'b0);
    endtask

    task automatic test_collision;
        do_read(29'h10, 2, 1'b1);
        do_read(29'h10, 4, 1'b0);
    endtask

    task automatic test_rd_in_wr;
        for (int k = 0; k < 3; k++) begin wdata[k] = 64'h5A5A_0000_0000_0020 + 64'(k); wbe[k] = 8'hFF; end
        do_write(29'h20, 3, -1, 1);
        do_read(29'h20, 3, 1'b0);
    endtask

    task automatic test_reset_mid;
        int t;
        int stray = 0;
        ddram_addr = 29'h10; ddram_burstcnt = 8'd8; ddram_rd = 1'b1;
        wait_ready("mid_accept");
        t = cyc + 1;
        for (int k = 0; k < 3; k++) q.push_back('{data: model[16 + k], cyc: t + L - 1 + k});
        @(negedge clk);
        ddram_rd = 1'b0;
        while (cyc < t + L + 1) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks += 3;
        if (ddram_dout_ready !== 1'b0) $display("FAIL mid_rst_ready: dout_ready=%b, required 0", ddram_dout_ready); else passes++;
        if (ddram_busy !== 1'b1) $display("FAIL mid_rst_busy: busy=%b, required 1", ddram_busy); else passes++;
        if (ddram_dout !== 64'd0) $display("FAIL mid_rst_dout: dout=%h, required 0", ddram_dout); else passes++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ddram_busy !== 1'b0) $display("FAIL mid_rel_busy: busy=%b, required 0", ddram_busy); else passes++;
        repeat (12) begin
            if (ddram_dout_ready !== 1'b0) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray != 0 || q.size() != 0)
            $display("FAIL mid_residual: %0d stray beats, %0d missing, required 0 0", stray, q.size());
        else
            passes++;
        q.delete();
        do_read(29'h10, 4, 1'b0);
    endtask

    task automatic illegal_req(input bit is_rd, input logic [7:0] cnt, input string what);
        ddram_addr = 29'd5; ddram_burstcnt = cnt;
        ddram_rd = is_rd; ddram_we = !is_rd;
        ddram_din = 64'hFEED_FACE_CAFE_BABE; ddram_be = 8'hFF;
        wait_ready(what);
        @(negedge clk);
        ddram_rd = 1'b0; ddram_we = 1'b0;
        checks++;
        if (proto_err !== 1'b1) $display("FAIL %s_err: proto_err=%b, required 1", what, proto_err); else passes++;
        @(negedge clk);
        checks++;
        if (proto_err !== 1'b0) $display("FAIL %s_pulse: proto_err=%b, required 0", what, proto_err); else passes++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_illegal;
        illegal_req(1'b1, 8'd0, "rd_len0");
        illegal_req(1'b0, 8'd129, "we_len129");
        do_read(29'd5, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall_be();
        test_wrap();
        test_collision();
        test_rd_in_wr();
        test_reset_mid();
        test_illegal();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
